// File: rtl/seq_chunk_mult_pkg.sv
// Shared types and elaboration helpers for the sequential chunked multiplier.
package seq_chunk_mult_pkg;

    // Control states: waiting for operands, accumulating partial products,
    // presenting the product until the consumer takes it.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of CHUNK-bit digits in one WIDTH-bit operand.
    function automatic int calc_nc(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Width of a digit counter that must reach nc-1. A single-digit operand
    // still gets a 1-bit counter so the datapath never has zero-width vectors.
    function automatic int cnt_width(input int nc);
        return (nc > 1) ? $clog2(nc) : 1;
    endfunction

endpackage

// File: rtl/chunk_mult.sv
// Combinational CHUNK x CHUNK -> 2*CHUNK unsigned digit multiplier.
// The sequential top shares a single instance across every digit pair.
module chunk_mult #(
    parameter int CHUNK = 2
) (
    input  logic [CHUNK-1:0]   x,
    input  logic [CHUNK-1:0]   y,
    output logic [2*CHUNK-1:0] prod
);

    // Both operands are widened first so the product cannot be truncated.
    assign prod = (2*CHUNK)'(x) * (2*CHUNK)'(y);

endmodule

// File: rtl/seq_chunk_mult.sv
// Iterative unsigned multiplier. Each WIDTH-bit operand is split into CHUNK-bit
// digits. Every clock in RUN, one digit pair goes through the shared chunk
// multiplier, and its partial product is shifted into a 2*WIDTH-bit accumulator.
// Valid/ready handshakes sit on both the operand side and the product side.
module seq_chunk_mult
    import seq_chunk_mult_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] p,
    output logic               busy
);

    localparam int NC = calc_nc(WIDTH, CHUNK);
    localparam int CW = cnt_width(NC);
    localparam logic [CW-1:0] LAST = CW'(NC - 1);

    // Operands must split into a whole number of digits.
    generate
        if (CHUNK < 1 || WIDTH < CHUNK || (WIDTH % CHUNK) != 0) begin : g_bad_params
            $error("seq_chunk_mult: WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [CW-1:0]      i_cnt;      // a-digit index (outer)
    logic [CW-1:0]      j_cnt;      // b-digit index (inner)
    logic [2*WIDTH-1:0] acc;
    logic [CHUNK-1:0]   a_digit;
    logic [CHUNK-1:0]   b_digit;
    logic [2*CHUNK-1:0] pp;
    logic [2*WIDTH-1:0] pp_shifted;
    logic               accept;
    logic               last_step;

    assign accept    = in_valid && in_ready;
    assign last_step = (i_cnt == LAST) && (j_cnt == LAST);

    // The accumulator drives the product directly. It is only cleared when a
    // new pair is accepted, so p keeps its last value through IDLE.
    assign p = acc;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state is updated with non-blocking assignments, so every
        // register in this design samples the values from before the edge.
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and handshake/status outputs.
    always_comb begin
        // NOTE: every output gets a default before the case, so no path can
        // leave one unassigned and infer a latch.
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_step) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Digit select. A loop of constant part-selects is used rather than a
    // variable part-select, so no index can point outside the operand.
    always_comb begin
        a_digit = '0;
        b_digit = '0;
        for (int k = 0; k < NC; k++) begin
            if (i_cnt == CW'(k)) begin
                a_digit = a_reg[k*CHUNK +: CHUNK];
            end
            if (j_cnt == CW'(k)) begin
                b_digit = b_reg[k*CHUNK +: CHUNK];
            end
        end
    end

    chunk_mult #(
        .CHUNK (CHUNK)
    ) u_chunk_mult (
        .x    (a_digit),
        .y    (b_digit),
        .prod (pp)
    );

    // The partial product is zero-extended to the accumulator width, then
    // weighted by the combined position of its two digits.
    assign pp_shifted = (2*WIDTH)'(pp) << (CHUNK * (int'(i_cnt) + int'(j_cnt)));

    // Operand capture, digit counters and accumulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg <= '0;
            b_reg <= '0;
            i_cnt <= '0;
            j_cnt <= '0;
            acc   <= '0;
        end else if (accept) begin
            a_reg <= a;
            b_reg <= b;
            i_cnt <= '0;
            j_cnt <= '0;
            acc   <= '0;
        end else if (state == RUN) begin
            acc <= acc + pp_shifted;
            if (j_cnt == LAST) begin
                j_cnt <= '0;
                // Counters go back to zero after the final digit pair, so
                // they never index past the last digit.
                i_cnt <= last_step ? '0 : i_cnt + CW'(1);
            end else begin
                j_cnt <= j_cnt + CW'(1);
            end
        end
    end

endmodule

// File: doc/seq_chunk_mult.md
Name: seq_chunk_mult

Overview:
- Parametrised, iterative unsigned multiplier. Splits each WIDTH-bit operand into CHUNK-bit digits and forms one digit-by-digit partial product per clock through a single shared chunk multiplier.
- Each partial product is shifted and accumulated into a 2*WIDTH-bit result.
- Sequential successor to the combinational 4-bit/2-bit-chunk multipliers. Trades area for latency and adds valid/ready handshakes on both sides, so it can sit in a streaming datapath.

Parameters:
- WIDTH, 8, operand width in bits; must be a multiple of CHUNK and >= CHUNK, otherwise elaboration fails.
- CHUNK, 2, digit width of the shared chunk multiplier.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept operands
- a  in  WIDTH  multiplicand, unsigned
- b  in  WIDTH  multiplier, unsigned
- out_valid  out  1  product valid
- out_ready  in  1  consumer accepts product
- p  out  2*WIDTH  product a*b
- busy  out  1  high while accumulating (RUN state)

Behaviour:
- Reset (async assert on rst_n low, sync release): state IDLE, in_ready=1, out_valid=0, busy=0, p=0, accumulator=0, digit counters=0.
- Reset mid-RUN or mid-DONE aborts the operation. The result is discarded and never presented.
- Derived constant NC = WIDTH/CHUNK. Total iterations = NC*NC.
- States and transitions:
  - IDLE: in_ready=1. On in_valid&&in_ready at edge T: latch a and b, clear the accumulator, clear counters i (a-digit) and j (b-digit), go to RUN.
  - RUN: in_ready=0, busy=1. Each edge: acc <= acc + (a_digit[i]*b_digit[j]) << (CHUNK*(i+j)).
    - j is the inner counter: j increments; when j wraps from NC-1 to 0, i increments.
    - The edge that processes (NC-1, NC-1) moves to DONE.
    - RUN therefore occupies exactly NC*NC edges (T+1 .. T+NC*NC).
  - DONE: out_valid=1, p=acc, busy=0, in_ready=0. p and out_valid hold stable until out_ready=1. On out_valid&&out_ready: go to IDLE, out_valid falls next cycle.
- Latency: out_valid is first high in the cycle after edge T+NC*NC, i.e. NC*NC cycles after acceptance. For WIDTH=8, CHUNK=2 that is 16 cycles.
- Throughput: one product per NC*NC+2 cycles minimum. This includes the DONE handshake cycle and the IDLE accept cycle.
- in_valid while not in_ready is ignored. The operands are not captured and the upstream must hold them.
- a and b may change freely after acceptance; the latched copies are used.
- Width rules:
  - The accumulator is 2*WIDTH bits wide. No overflow is possible because the maximum product is (2^WIDTH-1)^2.
  - Each partial product is 2*CHUNK bits, zero-extended before the shift.
- p holds its last value in IDLE. It is only meaningful while out_valid=1.
- out_ready asserted outside DONE has no effect.

Decomposition:
- Package seq_chunk_mult_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - a function computing NC from WIDTH and CHUNK;
  - a function returning the counter width, clog2(NC) with a minimum of 1.
- Sub-module chunk_mult: purely combinational, CHUNK x CHUNK -> 2*CHUNK unsigned. It has one instance and sits in the RUN datapath.
- The top level holds the FSM, the operand registers, the digit muxes, the shifter and the accumulator.

Test Plan:
- WIDTH=8, CHUNK=2, a=255, b=255, out_ready=1 -> out_valid high exactly 16 cycles after acceptance, p=65025, busy high for 16 cycles.
- a=0, b=173 and a=1, b=200 -> p=0, then p=200. Each result arrives after 16 cycles, and in_ready returns 1 the cycle after the output handshake.
- Backpressure: a=13, b=11, out_ready=0 for 10 cycles after out_valid -> p=143 and out_valid held stable throughout. A new in_valid pulse during the stall is not accepted.
- Reset mid-RUN: accept a=200, b=100, drop rst_n at cycle 7 -> outputs immediately at their reset values, no out_valid ever appears for that pair. The next pair a=3, b=5 yields p=15.
- WIDTH=16, CHUNK=2: a=16'hFFFF, b=16'hFFFF -> p=32'hFFFE0001 after 64 cycles. Follow with 1000 random pairs checked against a reference model, with random out_ready stalls.
- WIDTH=4, CHUNK=2, exhaustive 256 pairs back-to-back -> every p equals a*b and the latency is always 4 cycles.
